// File: rtl/seq_detector_param.sv
// Two-button serial bit-sequence detector with overlapping / non-overlapping match modes.
// Buttons are synchronised, edge-detected, shifted into num and compared against pattern once full.
module seq_detector_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] num,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {FILL, ARMED, HIT} state_t;

  logic a_s1, a_s2, a_d;
  logic b_s1, b_s2, b_d;
  logic [1:0] warm;
  logic rise_a, rise_b, one_rise;

  logic [FW-1:0] fill;
  logic          acc;
  logic          nonov;
  state_t        state;

  // warm masks the first edges after reset so a button held through release is not seen as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      a_d  <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      b_d  <= 1'b0;
      warm <= 2'd0;
    end else begin
      a_s1 <= A;
      a_s2 <= a_s1;
      a_d  <= a_s2;
      b_s1 <= B;
      b_s2 <= b_s1;
      b_d  <= b_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign rise_a   = a_s2 & ~a_d;
  assign rise_b   = b_s2 & ~b_d;
  assign one_rise = (rise_a ^ rise_b) && (warm == 2'd3) && !clr;

  // Bits are shifted on acceptance and compared one edge later; nonov latches mode at the match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= '0;
      fill      <= '0;
      match_cnt <= '0;
      out       <= 1'b0;
      acc       <= 1'b0;
      nonov     <= 1'b0;
      state     <= FILL;
    end else if (clr) begin
      num       <= '0;
      fill      <= '0;
      match_cnt <= '0;
      out       <= 1'b0;
      acc       <= 1'b0;
      nonov     <= 1'b0;
      state     <= FILL;
    end else begin
      acc <= one_rise;
      if (one_rise) begin
        num <= {num[WIDTH-2:0], rise_a};
        if (fill != FULL) fill <= fill + 1'b1;
      end
      if (state == HIT && nonov) begin
        state <= FILL;
        out   <= 1'b0;
        fill  <= one_rise ? FW'(1) : '0;
      end else if (acc) begin
        if (fill == FULL && num == pattern) begin
          state <= HIT;
          out   <= 1'b1;
          nonov <= mode;
          if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
        end else if (fill == FULL) begin
          state <= ARMED;
          out   <= 1'b0;
        end else begin
          state <= FILL;
          out   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a spec-level model pushes expectations per button press,
// which are popped and compared once the DUT has had time to respond.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0, clr = 1'b0, mode = 1'b0;
  logic [3:0] pattern = 4'b1011;
  logic [3:0] num, num2;
  logic       out, out2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] num;
    logic       out;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [3:0] m_num;
  int         m_fill;
  logic       m_out;
  int         m_cnt, m_cnt2;
  bit         m_flush;

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr(clr), .mode(mode),
    .pattern(pattern), .num(num), .out(out), .match_cnt(match_cnt)
  );

  seq_detector_param #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clr(clr), .mode(mode),
    .pattern(pattern), .num(num2), .out(out2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  task model_reset();
    m_num = 4'b0; m_fill = 0; m_out = 1'b0; m_cnt = 0; m_cnt2 = 0; m_flush = 1'b0;
    sb.delete();
  endtask

  // Model one press (possibly both buttons), push expectation, drive it, wait until t+3 settles
  task press(input bit a, input bit b);
    exp_t x;
    if (m_flush) begin m_fill = 0; m_out = 1'b0; m_flush = 1'b0; end
    if (a ^ b) begin
      m_num = {m_num[2:0], a};
      if (m_fill < 4) m_fill++;
      if (m_fill == 4 && m_num == pattern) begin
        m_out = 1'b1;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        m_flush = mode;
      end else m_out = 1'b0;
    end
    x.num = m_num; x.out = m_out; x.cnt = m_cnt[7:0]; x.cnt2 = m_cnt2[1:0];
    sb.push_back(x);
    @(negedge clk); A = a; B = b;
    @(negedge clk); A = 1'b0; B = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task clear_all();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_reset();
  endtask

  task test_reset();
    rst_n = 1'b0; pattern = 4'b1011; mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (num !== 4'b0 || out !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset: num=%b out=%b cnt=%0d cnt2=%0d expected all zero", num, out, match_cnt, match_cnt2);
    end
  endtask

  task test_basic();
    bit bits [4] = '{1, 0, 1, 1};
    foreach (bits[i]) begin
      press(bits[i], !bits[i]);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || out2 !== e.out || match_cnt !== e.cnt || match_cnt2 !== e.cnt2) begin
        failures++;
        $display("[TB] FAIL basic bit%0d: num=%b out=%b cnt=%0d cnt2=%0d expected num=%b out=%b cnt=%0d cnt2=%0d",
                 i, num, out, match_cnt, match_cnt2, e.num, e.out, e.cnt, e.cnt2);
      end
    end
  endtask

  task test_pattern_change();
    pattern = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pattern_change: out=%b expected 1", out);
    end
    pattern = 4'b1011;
  endtask

  task test_clr();
    @(negedge clk); clr = 1'b1; A = 1'b1;
    @(negedge clk); A = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (num !== 4'b0 || out !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL clr: num=%b out=%b cnt=%0d expected num=0000 out=0 cnt=0", num, out, match_cnt);
    end
  endtask

  task test_overlap();
    bit bits [6] = '{1, 0, 1, 0, 1, 0};
    clear_all(); pattern = 4'b1010; mode = 1'b0;
    foreach (bits[i]) begin
      press(bits[i], !bits[i]);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || out2 !== e.out || match_cnt !== e.cnt || match_cnt2 !== e.cnt2) begin
        failures++;
        $display("[TB] FAIL overlap bit%0d: num=%b out=%b cnt=%0d expected num=%b out=%b cnt=%0d",
                 i, num, out, match_cnt, e.num, e.out, e.cnt);
      end
    end
  endtask

  task test_nonoverlap();
    bit bits [6] = '{1, 0, 1, 0, 1, 0};
    clear_all(); pattern = 4'b1010; mode = 1'b1;
    foreach (bits[i]) begin
      press(bits[i], !bits[i]);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || match_cnt !== e.cnt || match_cnt2 !== e.cnt2) begin
        failures++;
        $display("[TB] FAIL nonoverlap bit%0d: num=%b out=%b cnt=%0d expected num=%b out=%b cnt=%0d",
                 i, num, out, match_cnt, e.num, e.out, e.cnt);
      end
      if (i == 3) begin
        @(posedge clk); #1;
        checks++;
        if (out !== 1'b0 || num !== 4'b1010) begin
          failures++;
          $display("[TB] FAIL nonoverlap_pulse: out=%b num=%b expected out=0 num=1010", out, num);
        end
      end
    end
    mode = 1'b0;
  endtask

  task test_simultaneous();
    bit as [5] = '{1, 0, 1, 1, 1};
    bit bs [5] = '{0, 1, 0, 1, 0};
    clear_all(); pattern = 4'b1011; mode = 1'b0;
    foreach (as[i]) begin
      press(as[i], bs[i]);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || match_cnt !== e.cnt) begin
        failures++;
        $display("[TB] FAIL simultaneous step%0d: num=%b out=%b cnt=%0d expected num=%b out=%b cnt=%0d",
                 i, num, out, match_cnt, e.num, e.out, e.cnt);
      end
    end
  endtask

  task test_saturate();
    clear_all(); pattern = 4'b1111; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || match_cnt !== e.cnt || match_cnt2 !== e.cnt2) begin
        failures++;
        $display("[TB] FAIL saturate bit%0d: out=%b cnt=%0d cnt2=%0d expected out=%b cnt=%0d cnt2=%0d",
                 i, out, match_cnt, match_cnt2, e.out, e.cnt, e.cnt2);
      end
    end
  endtask

  task test_zero_and_async_reset();
    pattern = 4'b0000; mode = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out !== 1'b0 || num !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL zero_no_input: out=%b num=%b expected out=0 num=0000", out, num);
    end
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (num !== e.num || out !== e.out || match_cnt !== e.cnt) begin
        failures++;
        $display("[TB] FAIL zero_pattern bit%0d: out=%b cnt=%0d expected out=%b cnt=%0d",
                 i, out, match_cnt, e.out, e.cnt);
      end
    end
    @(negedge clk); A = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (num !== 4'b0 || out !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: num=%b out=%b cnt=%0d expected all zero", num, out, match_cnt);
    end
    model_reset();
    pattern = 4'b0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (num !== 4'b0 || out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL held_through_reset: num=%b out=%b expected num=0000 out=0", num, out);
    end
    A = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern_change();
    test_clr();
    test_overlap();
    test_nonoverlap();
    test_simultaneous();
    test_saturate();
    test_zero_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving pattern and shift-register length (legal 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving match-counter width (legal 1..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port A  input  1  asynchronous button; a rising edge enters bit 1.
REQ-006 The block SHALL have port B  input  1  asynchronous button; a rising edge enters bit 0.
REQ-007 The block SHALL have port clr  input  1  synchronous clear of history, fill and counter.
REQ-008 The block SHALL have port mode  input  1  0 = overlapping detection, 1 = non-overlapping.
REQ-009 The block SHALL have port pattern  input  WIDTH  target sequence; MSB is the oldest bit.
REQ-010 The block SHALL have port num  output  WIDTH  shift-register contents; newest bit in LSB.
REQ-011 The block SHALL have port out  output  1  registered match flag.
REQ-012 The block SHALL have port match_cnt  output  CNT_W  saturating count of match events.

Function
REQ-013 A and B SHALL each pass through two synchroniser flops and one delay flop; rise = sync2 & ~delay.
REQ-014 Latency: A or B high first sampled at edge t SHALL shift num at edge t+2, and update out/match_cnt at edge t+3.
REQ-015 A single rise in a cycle SHALL shift num left one place and load the new bit into num[0].
REQ-016 A and B rising in the same cycle SHALL both be discarded: no shift, no fill change.
REQ-017 Fill counter SHALL count accepted bits from 0 and saturate at WIDTH; full = (fill == WIDTH).
REQ-018 FSM states SHALL be FILL (fill < WIDTH), ARMED (full, no match) and HIT (full, num == pattern).
REQ-019 Transitions SHALL be evaluated after each accepted bit: FILL->ARMED/HIT at full, ARMED<->HIT by comparison.
REQ-020 A bit accepted while the FSM is in HIT SHALL be compared again; the FSM SHALL stay in HIT on a repeat match.
REQ-021 out SHALL be 1 exactly while the FSM is in HIT, and SHALL hold its level between accepted bits.
REQ-022 match_cnt SHALL increment by 1 for each accepted bit that produces a match, including repeated overlapping hits.
REQ-023 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 Mode 0 (overlapping): fill SHALL remain WIDTH after a match, so shared suffix bits can form the next match.
REQ-025 Mode 1 (non-overlapping): the cycle after a match, fill SHALL reset to 0 and the FSM SHALL move to FILL.
REQ-026 In mode 1, out SHALL pulse for one cycle and num SHALL be retained.
REQ-027 Comparison SHALL use the live pattern value and SHALL be re-evaluated only when a bit is accepted; a pattern change alone SHALL NOT change out.
REQ-028 A mode change SHALL take effect at the next match event.
REQ-029 Asserted clr SHALL, at the next edge, set num=0, fill=0, match_cnt=0, out=0 and the FSM to FILL.
REQ-030 A rise in the same cycle as clr SHALL be discarded; clr has priority.
REQ-031 A match SHALL NOT be reported while the FSM is in FILL, even when num == pattern, e.g. pattern 0000 after reset.

Reset
REQ-032 When rst_n=0 the block SHALL immediately, without a clock, set num=0, out=0, match_cnt=0, fill=0, the FSM to FILL and all synchroniser/delay flops to 0.
REQ-033 Reset asserted mid-sequence SHALL discard all partial history; detection SHALL restart from an empty register.
REQ-034 Release of rst_n SHALL be synchronous to clk; a button held high through reset release SHALL NOT generate a rise.

Verification
REQ-035 Scenario 1: WIDTH=4, pattern=1011, mode=0, rises A,B,A,A -> num=1011, out=1 at t+3 after the last rise, match_cnt=1.
REQ-036 Scenario 2: overlap, pattern=1010, mode=0, bits 1,0,1,0,1,0 -> matches after bits 4 and 6, match_cnt=2, out stays 1 across bit 5? no: out=0 after bit 5 and out=1 after bit 6.
REQ-037 Scenario 3: same bits with mode=1 -> one match only (after bit 4), match_cnt=1, out is a one-cycle pulse.
REQ-038 Scenario 4: A and B rise in the same cycle -> num, fill and match_cnt unchanged; a subsequent single A rise shifts normally.
REQ-039 Scenario 5: CNT_W=2, 5 consecutive overlapping matches of pattern 1111 -> match_cnt sticks at 3.
REQ-040 Scenario 6: pattern=0000, reset, then no input -> out=0; four B rises -> out=1. Asserting rst_n=0 mid-sequence -> all outputs 0 before the next clk edge.
